// File: rtl/led_scan_ctrl_pkg.sv
// Shared scan-controller definitions: FSM states, matrix size and the level->duty mapping.
// Define SCAN_GAMMA_EN to map pixel levels through the gamma table instead of using them linearly.
package led_scan_ctrl_pkg;

    localparam int ROWS_DEF = 8;
    localparam int SLOTS    = 15;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_SHOW  = 2'd2
    } scan_state_e;

`ifdef SCAN_GAMMA_EN
    // Nibble n holds the duty for level n.
    localparam logic [63:0] GAMMA_LUT = {4'd15, 4'd13, 4'd11, 4'd10, 4'd8, 4'd7, 4'd6, 4'd5,
                                         4'd4,  4'd3,  4'd2,  4'd2,  4'd1, 4'd1, 4'd1, 4'd0};
`endif

    function automatic logic [3:0] level_to_duty(input logic [3:0] level);
`ifdef SCAN_GAMMA_EN
        return GAMMA_LUT[{level, 2'b00} +: 4];
`else
        return level;
`endif
    endfunction

endpackage

// File: rtl/led_scan_ctrl_pwm_cmp.sv
// Per-column PWM compare: maps each pixel level to a duty and drives the column while duty > slot.
module led_scan_ctrl_pwm_cmp
    import led_scan_ctrl_pkg::*;
#(
    parameter int LANES = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable_i,
    input  logic [LANES*4-1:0] level_i,
    input  logic [3:0]         slot_i,
    output logic [LANES-1:0]   col_drv_o
);

    logic [LANES-1:0] col_drv_d, col_drv_q;

    always_comb begin
        col_drv_d = '0;
        for (int c = 0; c < LANES; c++) begin
            col_drv_d[c] = enable_i && (level_to_duty(level_i[c*4 +: 4]) > slot_i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_drv_q <= '0;
        end else begin
            col_drv_q <= col_drv_d;
        end
    end

    assign col_drv_o = col_drv_q;

endmodule

// File: rtl/led_scan_ctrl.sv
// LED matrix scan scheduler: fetches one row of pixel levels from the LED RAM, then shows it with
// 15-slot PWM, stepping through all rows; the RAM address port is yielded whenever the pen path is busy.
module led_scan_ctrl
    import led_scan_ctrl_pkg::*;
#(
    parameter int SLOT_CYC = 1000,
    parameter int ROWS     = ROWS_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            enable,
    input  logic            ram_wr_busy,
    input  logic [3:0]      ram_data,
    output logic [ROWS-1:0] ram_addr_row,
    output logic [ROWS-1:0] ram_addr_col,
    output logic [ROWS-1:0] row_sel,
    output logic [ROWS-1:0] col_drv,
    output logic            frame_start
);

    localparam int RW = $clog2(ROWS);
    localparam int IW = RW + 1;
    localparam int CW = (SLOT_CYC > 1) ? $clog2(SLOT_CYC) : 1;

    localparam logic [RW-1:0]   LAST_IDX  = RW'(ROWS - 1);
    localparam logic [IW-1:0]   ISSUE_END = IW'(ROWS);
    localparam logic [CW-1:0]   LAST_CYC  = CW'(SLOT_CYC - 1);
    localparam logic [3:0]      LAST_SLOT = 4'(SLOTS - 1);
    localparam logic [ROWS-1:0] ONE_HOT0  = {{(ROWS - 1){1'b0}}, 1'b1};

    scan_state_e       state_q, state_d;
    logic [RW-1:0]     row_q, row_d;
    logic [IW-1:0]     issue_q, issue_d;
    logic              pend_q, pend_d;
    logic [RW-1:0]     pend_col_q, pend_col_d;
    logic [CW-1:0]     cyc_q, cyc_d;
    logic [3:0]        slot_q, slot_d;
    logic [ROWS*4-1:0] pix_q, pix_d;
    logic [ROWS-1:0]   row_sel_q, row_sel_d;
    logic              frame_start_q, frame_start_d;
    logic              presenting;

    // At most one read is in flight; if the pen path grabs the port before it is captured,
    // issue rewinds to that column so the buffer only ever holds confirmed reads.
    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        issue_d    = issue_q;
        pend_d     = pend_q;
        pend_col_d = pend_col_q;
        cyc_d      = cyc_q;
        slot_d     = slot_q;
        pix_d      = pix_q;

        if (!enable) begin
            state_d = ST_IDLE;
            row_d   = '0;
            pend_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_FETCH;
                    row_d   = '0;
                    issue_d = '0;
                    pend_d  = 1'b0;
                end
                ST_FETCH: begin
                    if (ram_wr_busy) begin
                        if (pend_q) begin
                            issue_d = {1'b0, pend_col_q};
                            pend_d  = 1'b0;
                        end
                    end else begin
                        pend_d = 1'b0;
                        if (pend_q) begin
                            pix_d[{pend_col_q, 2'b00} +: 4] = ram_data;
                        end
                        if (issue_q != ISSUE_END) begin
                            pend_d     = 1'b1;
                            pend_col_d = issue_q[RW-1:0];
                            issue_d    = issue_q + 1'b1;
                        end
                        if (pend_q && (pend_col_q == LAST_IDX)) begin
                            state_d = ST_SHOW;
                            cyc_d   = '0;
                            slot_d  = '0;
                        end
                    end
                end
                ST_SHOW: begin
                    if (cyc_q == LAST_CYC) begin
                        cyc_d = '0;
                        if (slot_q == LAST_SLOT) begin
                            slot_d  = '0;
                            state_d = ST_FETCH;
                            row_d   = (row_q == LAST_IDX) ? '0 : row_q + 1'b1;
                            issue_d = '0;
                            pend_d  = 1'b0;
                        end else begin
                            slot_d = slot_q + 4'd1;
                        end
                    end else begin
                        cyc_d = cyc_q + 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        row_sel_d     = (state_d == ST_SHOW) ? (ONE_HOT0 << row_d) : '0;
        frame_start_d = (state_d == ST_FETCH) && (state_q != ST_FETCH) && (row_d == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            row_q         <= '0;
            issue_q       <= '0;
            pend_q        <= 1'b0;
            pend_col_q    <= '0;
            cyc_q         <= '0;
            slot_q        <= '0;
            pix_q         <= '0;
            row_sel_q     <= '0;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            row_q         <= row_d;
            issue_q       <= issue_d;
            pend_q        <= pend_d;
            pend_col_q    <= pend_col_d;
            cyc_q         <= cyc_d;
            slot_q        <= slot_d;
            pix_q         <= pix_d;
            row_sel_q     <= row_sel_d;
            frame_start_q <= frame_start_d;
        end
    end

    // Address is dropped in the same cycle the pen path claims the port.
    assign presenting   = (state_q == ST_FETCH) && !ram_wr_busy && (issue_q != ISSUE_END);
    assign ram_addr_row = presenting ? (ONE_HOT0 << row_q) : '0;
    assign ram_addr_col = presenting ? (ONE_HOT0 << issue_q[RW-1:0]) : '0;

    assign row_sel     = row_sel_q;
    assign frame_start = frame_start_q;

    led_scan_ctrl_pwm_cmp #(
        .LANES(ROWS)
    ) u_pwm_cmp (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable_i (state_d == ST_SHOW),
        .level_i  (pix_d),
        .slot_i   (slot_d),
        .col_drv_o(col_drv)
    );

endmodule

// File: tb/tb_led_scan_ctrl.sv
// Self-checking bench for led_scan_ctrl: RAM model with pen-path contention, phase-level reference model.
module tb_led_scan_ctrl;

    localparam int SLOT_CYC = 2;
    localparam int SHOW_LEN = 15 * SLOT_CYC;

    logic       clk;
    logic       rst_n;
    logic       enable;
    logic       ram_wr_busy;
    logic [3:0] ram_data;
    logic [7:0] ram_addr_row;
    logic [7:0] ram_addr_col;
    logic [7:0] row_sel;
    logic [7:0] col_drv;
    logic       frame_start;

    logic [3:0] ram [8][8];
    logic [3:0] rdata_q;
    logic [3:0] junk_q;

    int totalChecks = 0;
    int passChecks  = 0;
    int failChecks  = 0;

`ifdef SCAN_GAMMA_EN
    int dutyTable [16] = '{0, 1, 1, 1, 2, 2, 3, 4, 5, 6, 7, 8, 10, 11, 13, 15};
`endif

    led_scan_ctrl #(
        .SLOT_CYC(SLOT_CYC),
        .ROWS    (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .ram_wr_busy (ram_wr_busy),
        .ram_data    (ram_data),
        .ram_addr_row(ram_addr_row),
        .ram_addr_col(ram_addr_col),
        .row_sel     (row_sel),
        .col_drv     (col_drv),
        .frame_start (frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int oneHotIdx(input logic [7:0] v);
        int idx;
        idx = -1;
        if ($countones(v) == 1) begin
            for (int i = 0; i < 8; i++) begin
                if (v[i]) idx = i;
            end
        end
        return idx;
    endfunction

    // RAM with one-cycle read latency; any cycle the pen path owns the port yields garbage data.
    always @(posedge clk) begin
        junk_q <= 4'($urandom);
        if (!ram_wr_busy && oneHotIdx(ram_addr_row) >= 0 && oneHotIdx(ram_addr_col) >= 0)
            rdata_q <= ram[oneHotIdx(ram_addr_row)][oneHotIdx(ram_addr_col)];
        else
            rdata_q <= 4'($urandom);
    end
    assign ram_data = ram_wr_busy ? junk_q : rdata_q;

    function automatic int duty(input logic [3:0] level);
`ifdef SCAN_GAMMA_EN
        return dutyTable[level];
`else
        return int'(level);
`endif
    endfunction

    function automatic logic [7:0] expCols(input int r, input int slot);
        logic [7:0] v;
        v = '0;
        for (int c = 0; c < 8; c++) v[c] = (duty(ram[r][c]) > slot);
        return v;
    endfunction

    // Column presented in fetch cycle k for a single busy burst [s, s+L): the read in flight when
    // the burst starts is lost, and issue resumes at that column once the port is free.
    function automatic logic [7:0] expAddrCol(input int k, input int s, input int L);
        int c;
        if (k < s) c = k;
        else if (k < s + L) c = -1;
        else c = ((s > 0) ? s - 1 : 0) + (k - s - L);
        return (c >= 0 && c < 8) ? (8'h01 << c) : 8'h00;
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        totalChecks++;
        assert (obs === exp) passChecks++;
        else begin
            failChecks++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic checkDark(input string tag);
        checkOutput({tag, " row_sel"}, 32'(row_sel), 0);
        checkOutput({tag, " col_drv"}, 32'(col_drv), 0);
        checkOutput({tag, " addr_row"}, 32'(ram_addr_row), 0);
        checkOutput({tag, " addr_col"}, 32'(ram_addr_col), 0);
        checkOutput({tag, " frame_start"}, 32'(frame_start), 0);
    endtask

    // One row: FETCH with a busy burst at fetch cycles [s, s+L), then showLen cycles of SHOW.
    task automatic applyStimulus(input int r, input bit expFrame, input int s, input int L,
                                 input int showLen);
        int  k;
        int  expLen;
        bit  inShow;
        expLen = (s <= 8) ? 9 + L + ((s > 0) ? 1 : 0) : 9;
        inShow = 1'b0;
        k = 0;
        while (!inShow && k <= expLen + 4) begin
            tick();
            ram_wr_busy = (k >= s) && (k < s + L);
            #1;
            if (row_sel !== 8'h00) begin
                inShow = 1'b1;
            end else begin
                checkOutput($sformatf("r%0d k%0d frame_start", r, k), 32'(frame_start),
                            (k == 0 && expFrame) ? 1 : 0);
                checkOutput($sformatf("r%0d k%0d addr_col", r, k), 32'(ram_addr_col),
                            32'(expAddrCol(k, s, L)));
                checkOutput($sformatf("r%0d k%0d addr_row", r, k), 32'(ram_addr_row),
                            (expAddrCol(k, s, L) != 0) ? 32'(8'h01 << r) : 0);
                checkOutput($sformatf("r%0d k%0d col_drv", r, k), 32'(col_drv), 0);
                k++;
            end
        end
        checkOutput($sformatf("r%0d fetch_len", r), 32'(k), 32'(expLen));
        for (int t = 0; t < showLen; t++) begin
            if (t > 0) begin
                tick();
                ram_wr_busy = 1'($urandom_range(0, 1));
                #1;
            end
            checkOutput($sformatf("r%0d t%0d row_sel", r, t), 32'(row_sel), 32'(8'h01 << r));
            checkOutput($sformatf("r%0d t%0d col_drv", r, t), 32'(col_drv),
                        32'(expCols(r, t / SLOT_CYC)));
            checkOutput($sformatf("r%0d t%0d frame_start", r, t), 32'(frame_start), 0);
            checkOutput($sformatf("r%0d t%0d addr", r, t), 32'({ram_addr_row, ram_addr_col}), 0);
        end
        ram_wr_busy = 1'b0;
    endtask

    initial begin
        rst_n       = 1'b0;
        enable      = 1'b0;
        ram_wr_busy = 1'b0;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                ram[r][c] = 4'($urandom);
        for (int c = 0; c < 8; c++) begin
            ram[0][c] = 4'(c);
            ram[3][c] = 4'd15;
            ram[4][c] = 4'd0;
        end
        ram[2][0] = 4'd12;
        ram[2][1] = 4'd1;

        repeat (2) tick();
        #1;
        checkDark("reset");
        tick();
        rst_n = 1'b1;
        repeat (3) begin
            tick();
            #1;
            checkDark("idle disabled");
        end

        enable = 1'b1;
        applyStimulus(0, 1'b1, 99, 0, SHOW_LEN);
        applyStimulus(1, 1'b0, 3, 3, SHOW_LEN);
        for (int r = 2; r < 8; r++)
            applyStimulus(r, 1'b0, $urandom_range(0, 10), $urandom_range(1, 4), SHOW_LEN);
        applyStimulus(0, 1'b1, $urandom_range(0, 10), $urandom_range(1, 4), SHOW_LEN);
        for (int r = 1; r < 5; r++)
            applyStimulus(r, 1'b0, $urandom_range(0, 10), $urandom_range(1, 4), SHOW_LEN);

        applyStimulus(5, 1'b0, $urandom_range(0, 10), $urandom_range(1, 4), 11);
        enable = 1'b0;
        repeat (3) begin
            tick();
            #1;
            checkDark("abort show");
        end

        enable = 1'b1;
        applyStimulus(0, 1'b1, 8, 2, SHOW_LEN);
        repeat (4) tick();
        #1;
        checkOutput("mid fetch addr_col", 32'(ram_addr_col), 32'h08);
        checkOutput("mid fetch addr_row", 32'(ram_addr_row), 32'h02);
        #2;
        rst_n = 1'b0;
        #1;
        checkDark("async reset");
        tick();
        enable = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (3) begin
            tick();
            #1;
            checkDark("post reset idle");
        end

        enable = 1'b1;
        applyStimulus(0, 1'b1, 0, 2, SHOW_LEN);
        applyStimulus(1, 1'b0, 99, 0, SHOW_LEN);
        applyStimulus(2, 1'b0, $urandom_range(0, 10), $urandom_range(1, 4), SHOW_LEN);

        $display("%0d/%0d checks passed", passChecks, totalChecks);
        $finish;
    end

endmodule
